// File: rtl/shift_pkg.sv
// Shared types and widths for the sequential 1-bit-per-cycle left shifter.
package shift_pkg;

    localparam int DATA_W  = 8;
    localparam int SHAMT_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } shl_state_t;

endpackage

// File: rtl/shl_step.sv
// One combinational left-shift step plus detection of a sign change caused by that step.
module shl_step
    import shift_pkg::*;
(
    input  logic [DATA_W-1:0] work_i,
    output logic [DATA_W-1:0] shifted_o,
    output logic              sign_chg_o
);

    assign shifted_o  = {work_i[DATA_W-2:0], 1'b0};
    // The sign bit changes on this step exactly when the top two bits differ beforehand.
    assign sign_chg_o = work_i[DATA_W-1] ^ work_i[DATA_W-2];

endmodule

// File: rtl/shift_left_seq_8.sv
// Sequential logical left shift of an 8-bit operand by b[2:0], one bit per clock.
// Define SHL_OVF_DETECT_EN to enable the sticky signed-overflow flag on ovf.
module shift_left_seq_8
    import shift_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] s,
    output logic              busy,
    output logic              done,
    output logic              ovf
);

    shl_state_t         state_q, state_d;
    logic [DATA_W-1:0]  work_q, work_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0]  s_q, s_d;
    logic [DATA_W-1:0]  step_out;
    logic               sign_chg;
    logic [SHAMT_W-1:0] shamt;

    assign shamt = b[SHAMT_W-1:0];

    shl_step u_step (
        .work_i     (work_q),
        .shifted_o  (step_out),
        .sign_chg_o (sign_chg)
    );

    // Only the low bits of b carry a shift amount.
    logic [DATA_W-SHAMT_W-1:0] unused_b_hi;
    assign unused_b_hi = b[DATA_W-1:SHAMT_W];

`ifdef SHL_OVF_DETECT_EN
    logic flag_q, flag_d;
    logic ovf_q, ovf_d;
`else
    logic unused_sign_chg;
    assign unused_sign_chg = sign_chg;
`endif

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
`ifdef SHL_OVF_DETECT_EN
        flag_d  = flag_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    work_d = a;
                    cnt_d  = shamt;
`ifdef SHL_OVF_DETECT_EN
                    flag_d = 1'b0;
`endif
                    if (shamt == '0) begin
                        // Zero shift goes straight to DONE, so the result is the operand itself.
                        state_d = DONE;
                        s_d     = a;
`ifdef SHL_OVF_DETECT_EN
                        ovf_d   = 1'b0;
`endif
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                work_d = step_out;
                cnt_d  = cnt_q - 3'd1;
`ifdef SHL_OVF_DETECT_EN
                flag_d = flag_q | sign_chg;
`endif
                if (cnt_q == 3'd1) begin
                    state_d = DONE;
                    s_d     = step_out;
`ifdef SHL_OVF_DETECT_EN
                    ovf_d   = flag_q | sign_chg;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            s_q     <= '0;
`ifdef SHL_OVF_DETECT_EN
            flag_q  <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
`ifdef SHL_OVF_DETECT_EN
            flag_q  <= flag_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign s    = s_q;
    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
`ifdef SHL_OVF_DETECT_EN
    assign ovf  = ovf_q;
`else
    assign ovf  = 1'b0;
`endif

endmodule

// File: doc/shift_left_seq_8.md
SHIFT_LEFT_SEQ_8 -- requirements
Module: shift_left_seq_8

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset, as in the following port lines.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 a  input  8  operand to shift; sampled on the accepted start edge.
REQ-006 b  input  8  shift amount; only b[2:0] is used, b[7:3] is ignored; sampled on the accepted start edge.
REQ-007 s  output  8  registered result, held until the next result is written.
REQ-008 busy  output  1  high whenever the state is not IDLE.
REQ-009 done  output  1  single-cycle pulse marking that s (and ovf) are valid.
REQ-010 ovf  output  1  signed-overflow flag, held together with s.

Function
REQ-011 The FSM SHALL have exactly three states, IDLE, SHIFT and DONE, with busy = (state != IDLE).
REQ-012 Start acceptance SHALL follow these rules:
- A start seen high in IDLE is accepted on that edge (edge 0).
- On edge 0 the block loads a working register with a and a counter with N = b[2:0].
- On edge 0 the next state is SHIFT if N != 0, otherwise DONE.
REQ-013 On each edge in SHIFT, the block SHALL:
- set the working register to {work[6:0], 1'b0};
- decrement the counter;
- move to DONE on the edge where the counter reaches 0.
REQ-014 SHIFT SHALL last exactly N cycles; the result is the logical left shift of a by N, truncated to 8 bits, and zeros fill from the LSB.
REQ-015 On the edge that enters DONE, s SHALL be written with the working register.
REQ-016 done SHALL be high for exactly the one cycle spent in DONE, which is the cycle after edge N (edge 0 is the start edge); the total latency from start to done is N+1 cycles.
REQ-017 DONE SHALL return to IDLE unconditionally on the next edge.
REQ-018 A start arriving in SHIFT or DONE SHALL be ignored, not queued, and SHALL NOT disturb a, b, the counter or s.
REQ-019 Back-to-back operation SHALL be possible: a start in the first IDLE cycle after DONE is accepted, giving a minimum issue interval of N+2 cycles.
REQ-020 s and ovf SHALL change only on entry to DONE or on reset.

Reset
REQ-021 While rst_n is low at a clock edge, the block SHALL set:
- state to IDLE;
- s to 0x00;
- done, busy and ovf to 0;
- the counter and working register to 0.
REQ-022 Reset during SHIFT or DONE SHALL abort the operation with no done pulse and with s forced to 0x00.
REQ-023 A start asserted on the same edge that rst_n is low SHALL be ignored.

Configuration
REQ-024 The macro SHL_OVF_DETECT_EN SHALL control overflow detection.
REQ-025 With SHL_OVF_DETECT_EN defined, overflow detection SHALL work as follows:
- A sticky flag is cleared on the start edge.
- The flag is set on any SHIFT edge where work[7] != work[6] before that shift.
- The flag is copied to ovf on entry to DONE.
- For N = 0, ovf = 0.
REQ-026 Without SHL_OVF_DETECT_EN, ovf SHALL be tied to constant 0 and no flag register SHALL exist; all other behaviour is identical.

Structure
REQ-027 Package shift_pkg SHALL hold:
- localparam DATA_W = 8;
- localparam SHAMT_W = 3;
- the state enum typedef shl_state_t {IDLE, SHIFT, DONE}.
REQ-028 A sub-module shl_step SHALL implement one combinational 1-bit left shift plus the sign-change detect, and SHALL be instantiated once.
REQ-029 The block SHALL NOT contain a barrel shifter; exactly one bit is shifted per cycle.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- a=0x81, b=0x01 -> done one cycle after edge 1, s=0x02, ovf=1 (with macro).
- a=0x13, b=0x03 -> s=0x98, done one cycle after edge 3, ovf=1 (set on the 3rd shift).
- a=0xF0, b=0x03 -> s=0x80, ovf=0; then a=0x5A, b=0x00 -> s=0x5A, done one cycle after edge 0, ovf=0.
- a=0x01, b=0xFD (shift amount 5) -> s=0x20; pulse start again mid-SHIFT with a=0xFF -> ignored, s still 0x20.
- a=0x0F, b=0x06; drop rst_n on the 3rd SHIFT edge -> no done pulse, s=0x00, busy=0; next start a=0x0F, b=0x01 -> s=0x1E.
- Build without SHL_OVF_DETECT_EN, repeat the a=0x81, b=0x01 scenario -> s=0x02, ovf=0.
